// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N_CH synchronous FIFOs into one ready/valid stream.
// Grants one channel at a time for up to BURST_LEN reads, credit-limited by a 2-entry output buffer.
module fifo_rr_drain #(
  parameter int N_CH      = 4,
  parameter int DIN_WIDTH = 16,
  parameter int BURST_LEN = 8,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_CH-1:0]           fifo_empty,
  output logic [N_CH-1:0]           fifo_read_req,
  input  logic [N_CH*DIN_WIDTH-1:0] fifo_rdata,
  input  logic [N_CH-1:0]           fifo_r_valid,
  output logic [DIN_WIDTH-1:0]      dout,
  output logic [CH_W-1:0]           dout_ch,
  output logic                      dout_last,
  output logic                      dout_valid,
  input  logic                      dout_ready
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      g_q, g_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 infl_q, infl_d;
  logic [CH_W-1:0]      infl_ch_q, infl_ch_d;
  logic                 infl_last_q, infl_last_d;
  logic [DIN_WIDTH-1:0] buf_data_q [2];
  logic [DIN_WIDTH-1:0] buf_data_d [2];
  logic [CH_W-1:0]      buf_ch_q [2];
  logic [CH_W-1:0]      buf_ch_d [2];
  logic [1:0]           buf_last_q, buf_last_d;
  logic [1:0]           occ_q, occ_d;

  logic                 pop, wr, rd, credit_ok, found, wr_slot;
  logic [DIN_WIDTH-1:0] wr_data;

  assign pop       = (occ_q != 2'd0) & dout_ready;
  assign wr        = infl_q & fifo_r_valid[infl_ch_q];
  assign wr_data   = fifo_rdata[int'(infl_ch_q)*DIN_WIDTH +: DIN_WIDTH];
  // Words that will sit in the buffer after this cycle must leave room for one more return.
  assign credit_ok = ({1'b0, occ_q} + {2'b00, infl_q}) <= (3'd1 + {2'b00, pop});

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    infl_d        = 1'b0;
    infl_ch_d     = infl_ch_q;
    infl_last_d   = infl_last_q;
    fifo_read_req = '0;
    rd            = 1'b0;
    found         = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          for (int k = 0; k < N_CH; k++) begin
            if (!found && !fifo_empty[(int'(ptr_q) + k) % N_CH]) begin
              found = 1'b1;
              g_d   = CH_W'((int'(ptr_q) + k) % N_CH);
            end
          end
        end
        if (found) begin
          state_d = GRANT;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        rd = ~fifo_empty[g_q] & enable & credit_ok & (cnt_q < CNT_W'(BURST_LEN));
        fifo_read_req[g_q] = rd;
        if (rd) begin
          cnt_d       = cnt_q + 1'b1;
          infl_d      = 1'b1;
          infl_ch_d   = g_q;
          infl_last_d = (cnt_q == CNT_W'(BURST_LEN - 1));
        end
        if ((rd && (cnt_q == CNT_W'(BURST_LEN - 1))) || fifo_empty[g_q] || !enable) begin
          state_d = IDLE;
          ptr_d   = CH_W'((int'(g_q) + 1) % N_CH);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: entry 0 is the head; a pop shifts entry 1 forward.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_ch_d   = buf_ch_q;
    buf_last_d = buf_last_q;
    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_ch_d[0]   = buf_ch_q[1];
      buf_last_d[0] = buf_last_q[1];
    end
    wr_slot = !((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));
    if (wr) begin
      buf_data_d[wr_slot] = wr_data;
      buf_ch_d[wr_slot]   = infl_ch_q;
      buf_last_d[wr_slot] = infl_last_q;
    end
    occ_d = occ_q + {1'b0, wr} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      g_q         <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_ch_q   <= '0;
      infl_last_q <= 1'b0;
      buf_data_q  <= '{default: '0};
      buf_ch_q    <= '{default: '0};
      buf_last_q  <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_ch_q   <= infl_ch_d;
      infl_last_q <= infl_last_d;
      buf_data_q  <= buf_data_d;
      buf_ch_q    <= buf_ch_d;
      buf_last_q  <= buf_last_d;
      occ_q       <= occ_d;
    end
  end

  assign dout       = buf_data_q[0];
  assign dout_ch    = buf_ch_q[0];
  assign dout_last  = buf_last_q[0];
  assign dout_valid = (occ_q != 2'd0);

endmodule
